// File: rtl/store_lane_align.sv
// store_lane_align: MEM-stage store path. It narrows a register value to the
// addressed byte or halfword, replicates it across the 32-bit write word, and
// drives a single word-aligned memory beat with byte enables. Misaligned and
// reserved-size stores are trapped as a one-cycle error pulse and never
// reach the memory side.
module store_lane_align #(
  parameter bit BIG_ENDIAN = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_size,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic             err_valid,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] store_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, ERR} state_t;

  state_t      state_reg, state_next;
  logic        accept;
  logic        legal;
  logic [1:0]  byte_lane;
  logic        half_sel;
  logic [3:0]  be_byte;
  logic [3:0]  be_half;
  logic [3:0]  be_sel;
  logic [31:0] wdata_sel;

  assign accept = req_valid && req_ready;

  // Big-endian mirrors the lane order: byte address 0 lands in lane 3 and
  // the lower halfword address lands in the upper half of the word.
  assign byte_lane = BIG_ENDIAN ? (2'd3 - req_addr[1:0]) : req_addr[1:0];
  assign half_sel  = req_addr[1] ^ BIG_ENDIAN;

  // Per-lane enable decode for byte and halfword stores.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign be_byte[gi] = (byte_lane == 2'(gi));
      assign be_half[gi] = (half_sel == 1'(gi / 2));
    end
  endgenerate

  // Alignment check and lane selection for the incoming request.
  always_comb begin
    legal     = 1'b0;
    be_sel    = 4'hf;
    wdata_sel = req_data;
    case (req_size)
      2'b00: begin
        legal     = 1'b1;
        be_sel    = be_byte;
        wdata_sel = {4{req_data[7:0]}};
      end
      2'b01: begin
        legal     = ~req_addr[0];
        be_sel    = be_half;
        wdata_sel = {2{req_data[15:0]}};
      end
      2'b10: begin
        legal     = (req_addr[1:0] == 2'b00);
        be_sel    = 4'hf;
        wdata_sel = req_data;
      end
      default: begin
        legal     = 1'b0;
        be_sel    = 4'h0;
        wdata_sel = req_data;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake outputs; the handshake flags come straight off
  // the state register so reset drops mem_valid immediately.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    err_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = legal ? ISSUE : ERR;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready) state_next = IDLE;
      end
      ERR: begin
        err_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat and trap payload registers, captured on accept and held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      err_addr  <= '0;
    end else if (accept) begin
      if (legal) begin
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= wdata_sel;
        mem_be    <= be_sel;
      end else begin
        mem_be    <= 4'h0;
        err_addr  <= req_addr;
      end
    end
  end

  // Completed-beat counter; wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                store_count <= '0;
    else if (state_reg == ISSUE && mem_ready) store_count <= store_count + 1'b1;
  end

endmodule

// File: tb/tb_store_lane_align.sv
// Bench for store_lane_align: two instances (little-endian with a 4-bit
// counter, big-endian with the default counter) share one request stream.
// A transaction-level model predicts both, a negedge process compares every
// cycle, and directed literal checks pin the model to hand-derived values.
module tb_store_lane_align;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_ready = 1'b0;

  logic        rdy0, mv0, ev0, rdy1, mv1, ev1;
  logic [31:0] ma0, mw0, ea0, ma1, mw1, ea1;
  logic [3:0]  be0, be1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;
  int acc   = 0;

  always #5 clk = ~clk;

  store_lane_align #(.BIG_ENDIAN(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mv0), .mem_ready(mem_ready), .mem_addr(ma0), .mem_wdata(mw0),
    .mem_be(be0), .err_valid(ev0), .err_addr(ea0), .store_count(cnt0)
  );

  store_lane_align #(.BIG_ENDIAN(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mv1), .mem_ready(mem_ready), .mem_addr(ma1), .mem_wdata(mw1),
    .mem_be(be1), .err_valid(ev1), .err_addr(ea1), .store_count(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: a beat is outstanding; m_err: a trap is being reported.
  logic        m_busy = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_eaddr = '0;
  logic [3:0]  m_be0 = '0, m_be1 = '0;
  int          m_cnt = 0;

  function automatic logic [3:0] lane_mask(input logic [31:0] a, input logic [1:0] s, input bit be);
    int off, idx;
    off = int'(a % 4);
    if (s == 2'b00) begin
      idx = be ? 3 - off : off;
      return 4'(1 << idx);
    end
    if (s == 2'b01) begin
      idx = off / 2;
      if (be) idx = 1 - idx;
      return 4'(3 << (2 * idx));
    end
    return 4'hf;
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return 1'b1;
    if (s == 2'b01) return (a % 2) == 0;
    if (s == 2'b10) return (a % 4) == 0;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_eaddr <= '0; m_be0 <= '0; m_be1 <= '0; m_cnt <= 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_cnt  <= m_cnt + 1;
        m_busy <= 1'b0;
      end
    end else if (m_err) begin
      m_err <= 1'b0;
    end else if (req_valid) begin
      if (is_legal(req_addr, req_size)) begin
        m_busy  <= 1'b1;
        m_addr  <= req_addr - (req_addr % 4);
        m_wdata <= (req_size == 2'b00) ? req_data[7:0] * 32'h01010101 :
                   (req_size == 2'b01) ? req_data[15:0] * 32'h00010001 : req_data;
        m_be0   <= lane_mask(req_addr, req_size, 1'b0);
        m_be1   <= lane_mask(req_addr, req_size, 1'b1);
      end else begin
        m_err   <= 1'b1;
        m_eaddr <= req_addr;
        m_be0   <= '0;
        m_be1   <= '0;
      end
    end
  end

  // Counts accepted requests on the little-endian instance.
  always @(posedge clk) if (req_valid && rdy0) acc <= acc + 1;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready0", 32'(rdy0), 32'(!m_busy && !m_err));
    chk("ready1", 32'(rdy1), 32'(!m_busy && !m_err));
    chk("mvalid0", 32'(mv0), 32'(m_busy));
    chk("mvalid1", 32'(mv1), 32'(m_busy));
    chk("evalid0", 32'(ev0), 32'(m_err));
    chk("evalid1", 32'(ev1), 32'(m_err));
    chk("eaddr0", ea0, m_eaddr);
    chk("eaddr1", ea1, m_eaddr);
    chk("count0", 32'(cnt0), 32'(m_cnt % 16));
    chk("count1", 32'(cnt1), 32'(m_cnt % 65536));
    if (m_busy || m_err || reset) begin
      chk("be0", 32'(be0), 32'(m_be0));
      chk("be1", 32'(be1), 32'(m_be1));
    end
    if (m_busy || reset) begin
      chk("maddr0", ma0, m_addr);
      chk("maddr1", ma1, m_addr);
      chk("wdata0", mw0, m_wdata);
      chk("wdata1", mw1, m_wdata);
    end
  end

  // Present one request once the block is ready; returns at the negedge
  // right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("send_timeout", 32'(rdy0), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  logic [31:0] err_tab_addr [3];
  logic [1:0]  err_tab_size [3];
  int acc0;

  initial begin
    err_tab_addr[0] = 32'h3001; err_tab_size[0] = 2'b10;
    err_tab_addr[1] = 32'h3001; err_tab_size[1] = 2'b11;
    err_tab_addr[2] = 32'h3001; err_tab_size[2] = 2'b01;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mvalid", 32'(mv0), 32'd0);
    chk("rst_be", 32'(be0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);
    reset = 1'b0;
    mem_ready = 1'b1;

    // Byte store, little-endian lane 3 / big-endian lane 0.
    send(32'h1003, 32'hDEADBEEF, 2'b00);
    chk("byte_mvalid", 32'(mv0), 32'd1);
    chk("byte_addr", ma0, 32'h1000);
    chk("byte_wdata", mw0, 32'hEFEFEFEF);
    chk("byte_be_le", 32'(be0), 32'b1000);
    chk("byte_be_be", 32'(be1), 32'b0001);
    @(negedge clk); #1;
    chk("byte_count", 32'(cnt0), 32'd1);

    // Halfword with a three-cycle stall.
    mem_ready = 1'b0;
    send(32'h2002, 32'h0000ABCD, 2'b01);
    chk("half_wdata", mw0, 32'hABCDABCD);
    chk("half_be_le", 32'(be0), 32'b1100);
    chk("half_be_be", 32'(be1), 32'b0011);
    repeat (3) @(negedge clk);
    #1;
    chk("stall_mvalid", 32'(mv0), 32'd1);
    chk("stall_wdata", mw0, 32'hABCDABCD);
    chk("stall_count", 32'(cnt0), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("half_done_mvalid", 32'(mv0), 32'd0);
    chk("half_count", 32'(cnt0), 32'd2);

    // Illegal stores: misaligned word, reserved size, misaligned half.
    for (int i = 0; i < 3; i++) begin
      send(err_tab_addr[i], 32'h55AA55AA, err_tab_size[i]);
      chk("err_pulse", 32'(ev0), 32'd1);
      chk("err_addr", ea0, 32'h3001);
      chk("err_mvalid", 32'(mv0), 32'd0);
      chk("err_be", 32'(be0), 32'd0);
      @(negedge clk); #1;
      chk("err_clear", 32'(ev0), 32'd0);
      chk("err_count", 32'(cnt0), 32'd2);
    end

    // Lane mirroring.
    send(32'h4000, 32'h00000012, 2'b00);
    chk("be_byte_be", 32'(be1), 32'b1000);
    chk("be_byte_le", 32'(be0), 32'b0001);
    chk("be_byte_wdata", mw1, 32'h12121212);
    send(32'h4000, 32'h0000BEEF, 2'b01);
    chk("be_half_be", 32'(be1), 32'b1100);
    chk("be_half_le", 32'(be0), 32'b0011);
    @(negedge clk); #1;
    chk("be_count", 32'(cnt1), 32'd4);

    // Asynchronous reset in the middle of a stalled beat.
    mem_ready = 1'b0;
    send(32'h5000, 32'hCAFEF00D, 2'b10);
    chk("pre_rst_mvalid", 32'(mv0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mvalid0", 32'(mv0), 32'd0);
    chk("async_rst_mvalid1", 32'(mv1), 32'd0);
    chk("async_rst_count", 32'(cnt1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_ready", 32'(rdy0), 32'd1);

    // Throughput and counter wrap: request held high for 34 cycles.
    mem_ready = 1'b1;
    acc0 = acc;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h6000 + 32'(k * 4);
      req_data  = 32'(k) * 32'h01000001;
      req_size  = 2'b10;
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("tput_accepts", 32'(acc - acc0), 32'd17);
    chk("wrap_count4", 32'(cnt0), 32'd1);
    chk("wrap_count16", 32'(cnt1), 32'd17);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_lane_align.md
Name: store_lane_align

Overview:
- MEM-stage store path of the pipeline; the write-side counterpart of immediate/load sign extension.
- Takes a 32-bit register value plus size and byte address, and narrows it to the addressed byte or halfword.
- Drives a word-aligned data-memory write with byte enables, using a valid/ready handshake on both sides.
- Misaligned or reserved-size stores are trapped and reported; they produce no memory write.

Parameters:
- BIG_ENDIAN, 0, lane order: 0 = little-endian (byte addr 0 -> lane 0, bits 7:0); 1 = big-endian (byte addr 0 -> lane 3, bits 31:24).
- CNT_W, 16, width of the completed-store counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request from the pipeline.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  32  byte address.
- req_data  input  32  register (rt) value; low bits are used for byte and halfword stores.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- mem_valid  output  1  write beat pending on the memory side.
- mem_ready  input  1  memory accepts the beat.
- mem_addr  output  32  word-aligned address, {req_addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables; bit i enables bits 8i+7:8i.
- err_valid  output  1  one-cycle misalignment trap pulse.
- err_addr  output  32  faulting byte address; held until the next error.
- store_count  output  CNT_W  number of completed memory beats; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, mem_valid = 0, err_valid = 0.
  - mem_addr, mem_wdata, err_addr, store_count = 0; mem_be = 0000.
  - Reset during ISSUE abandons the beat; the memory side sees mem_valid fall without a handshake.
- FSM states:
  - IDLE: req_ready = 1.
  - ISSUE: mem_valid = 1.
  - ERR: err_valid = 1.
  - req_ready = 1 only in IDLE; no request is accepted in ISSUE or ERR.
- Accept: req_valid and req_ready high at a clock edge. All mem_* / err_* outputs are registered at that edge.
- Legality checks:
  - Byte: always legal.
  - Half: legal iff addr[0] = 0.
  - Word: legal iff addr[1:0] = 00.
  - Size 11: always illegal.
- Legal accept -> ISSUE on the next cycle (1-cycle latency).
  - Byte: mem_wdata = {4{data[7:0]}}; mem_be = one-hot lane of addr[1:0].
  - Half: mem_wdata = {2{data[15:0]}}; mem_be = 0011 for addr[1] = 0, 1100 for addr[1] = 1 (LE).
  - Word: mem_wdata = data; mem_be = 1111.
  - BIG_ENDIAN = 1 mirrors lanes: byte lane = 3 - addr[1:0]; half uses 1100 for addr[1] = 0.
- ISSUE:
  - mem_valid, mem_addr, mem_wdata and mem_be stay stable until mem_ready.
  - On the mem_ready edge: store_count += 1, then go to IDLE. mem_valid is 0 the following cycle.
  - mem_ready already high on the first ISSUE cycle gives a 1-cycle beat.
  - Back-to-back stores: minimum spacing of 2 cycles between accepts.
- Illegal accept -> ERR for exactly one cycle:
  - err_valid = 1, err_addr = req_addr, mem_valid stays 0, mem_be = 0000.
  - Then return to IDLE.
- mem_ready is ignored outside ISSUE.
- req_* inputs are ignored when req_ready = 0.
- store_count wraps from all-ones to 0 with no flag.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle during ISSUE -> mem_valid = 0 immediately; store_count = 0; req_ready = 1 after release.
- Byte store, LE: addr = 0x1003, data = 0xDEADBEEF, size 00 -> next cycle mem_addr = 0x1000, mem_wdata = 0xEFEFEFEF, mem_be = 1000, mem_valid = 1.
- Half store with stall: addr = 0x2002, data = 0x0000ABCD, mem_ready held low 3 cycles:
  - mem_wdata = 0xABCDABCD, mem_be = 1100, outputs stable for all 4 ISSUE cycles.
  - store_count increments by 1 on the ready edge.
- Misaligned word: addr = 0x3001, size 10 -> err_valid pulses 1 cycle, err_addr = 0x3001, no mem_valid, store_count unchanged.
  - Same for size 11 and for half at addr = 0x3001.
- BIG_ENDIAN = 1, byte at addr = 0x4000, data = 0x12 -> mem_be = 1000.
  - Half at addr = 0x4000 -> mem_be = 1100.
- Throughput/wrap: CNT_W = 4, 17 word stores with mem_ready tied 1 -> accepts every 2nd cycle, store_count reads 1 at the end.
